// File: rtl/bpu_btb_ctrl.sv
// bpu_btb_ctrl: BTB port controller in front of a 256 x 39b single-port RAM
// (1-cycle read, write-first). Serves fetch lookups and queued commit
// updates (read-modify-write) on the one port; lookups have priority.
// After reset the RAM is swept to zero before lookups are accepted.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_lk_valid/o_lk_ready   lookup handshake, i_lk_pc fetch PC
//   o_rsp_valid/hit/taken   lookup response, 1 cycle after accept
//   o_rsp_target            predicted target
//   i_upd_valid/o_upd_ready update handshake into the update FIFO
//   i_upd_pc/taken/target   resolved branch
//   o_ram_we/addr/din       RAM port, i_ram_dout RAM read data
//   o_perf_lk, o_perf_hit   lookup / hit counters
// Option macro: BPU_PERF_CNT_EN builds the perf counters (else tied 0).

module bpu_btb_ctrl #(
   parameter int unsigned UPD_DEPTH = 2,
   parameter logic [1:0]  CTR_ALLOC = 2'b10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_lk_valid,
   output logic        o_lk_ready,
   input  logic [31:0] i_lk_pc,
   output logic        o_rsp_valid,
   output logic        o_rsp_hit,
   output logic        o_rsp_taken,
   output logic [31:0] o_rsp_target,
   input  logic        i_upd_valid,
   output logic        o_upd_ready,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target,
   output logic        o_ram_we,
   output logic [7:0]  o_ram_addr,
   output logic [38:0] o_ram_din,
   input  logic [38:0] i_ram_dout,
   output logic [31:0] o_perf_lk,
   output logic [31:0] o_perf_hit
);

   localparam int unsigned AW = $clog2(UPD_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(UPD_DEPTH);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_UPD_WR
   } state_t;

   typedef struct packed {
      logic [7:0]  idx;
      logic [5:0]  tag;
      logic        taken;
      logic [29:0] tgt;
   } upd_t;

   typedef struct packed {
      logic        vld;
      logic [1:0]  ctr;
      logic [5:0]  tag;
      logic [29:0] tgt;
   } ent_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_init_cnt;
   upd_t          r_fifo [UPD_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic          r_rsp_pend;
   logic [5:0]    r_lk_tag;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_upd_go;
   logic          w_lk_acc;
   logic          w_lk_ready;
   logic          w_we;
   logic [7:0]    w_addr;
   ent_t          w_din;
   upd_t          w_upd_in;
   upd_t          w_head;
   ent_t          w_ent;
   logic          w_ent_hit;
   logic [1:0]    w_ctr_nxt;
   logic          w_rsp_hit;
   logic          w_unused;

   // ---------------- update FIFO ----------------
   assign w_full  = (r_cnt == CNT_FULL);
   assign w_empty = (r_cnt == '0);
   assign w_push  = i_upd_valid & ~w_full;
   assign w_head  = r_fifo[r_rd_ptr];

   always_comb begin
      w_upd_in       = '0;
      w_upd_in.idx   = i_upd_pc[9:2];
      w_upd_in.tag   = i_upd_pc[15:10];
      w_upd_in.taken = i_upd_taken;
      w_upd_in.tgt   = i_upd_target[31:2];
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_fifo[r_wr_ptr] <= w_upd_in;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Drain when nothing else wants the port, or when the
   // FIFO is full and would otherwise back-pressure commit.
   assign w_upd_go = ~w_empty & (~i_lk_valid | w_full);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= S_INIT;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_init_cnt <= '0;
      else if (r_state == S_INIT)
         r_init_cnt <= r_init_cnt + 8'd1;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_INIT:
            if (r_init_cnt == 8'hFF)
               w_state_nxt = S_IDLE;
         S_IDLE:
            if (w_upd_go)
               w_state_nxt = S_UPD_WR;
         S_UPD_WR:
            w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_INIT;
      endcase
   end

   // ---------------- RMW counter / hit ----------------
   assign w_ent     = ent_t'(i_ram_dout);
   assign w_ent_hit = w_ent.vld & (w_ent.tag == w_head.tag);

   always_comb begin
      w_ctr_nxt = w_ent.ctr;
      if (w_head.taken) begin
         if (w_ent.ctr != 2'b11)
            w_ctr_nxt = w_ent.ctr + 2'b01;
      end else begin
         if (w_ent.ctr != 2'b00)
            w_ctr_nxt = w_ent.ctr - 2'b01;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_lk_ready = 1'b0;
      w_lk_acc   = 1'b0;
      w_pop      = 1'b0;
      w_we       = 1'b0;
      w_addr     = '0;
      w_din      = '0;
      unique case (r_state)
         S_INIT: begin
            w_we   = 1'b1;
            w_addr = r_init_cnt;
         end
         S_IDLE: begin
            if (w_upd_go) begin
               w_addr = w_head.idx;
            end else begin
               w_lk_ready = 1'b1;
               if (i_lk_valid) begin
                  w_lk_acc = 1'b1;
                  w_addr   = i_lk_pc[9:2];
               end
            end
         end
         S_UPD_WR: begin
            w_pop  = 1'b1;
            w_addr = w_head.idx;
            if (w_ent_hit) begin
               w_we      = 1'b1;
               w_din.vld = 1'b1;
               w_din.ctr = w_ctr_nxt;
               w_din.tag = w_head.tag;
               w_din.tgt = w_head.taken ?
                           w_head.tgt : w_ent.tgt;
            end else if (w_head.taken) begin
               w_we      = 1'b1;
               w_din.vld = 1'b1;
               w_din.ctr = CTR_ALLOC;
               w_din.tag = w_head.tag;
               w_din.tgt = w_head.tgt;
            end
         end
         default: begin
            w_addr = '0;
         end
      endcase
   end

   // ---------------- lookup response ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rsp_pend <= 1'b0;
         r_lk_tag   <= '0;
      end else begin
         r_rsp_pend <= w_lk_acc;
         if (w_lk_acc)
            r_lk_tag <= i_lk_pc[15:10];
      end
   end

   assign w_rsp_hit = r_rsp_pend & w_ent.vld &
                      (w_ent.tag == r_lk_tag);

   assign o_rsp_valid  = r_rsp_pend;
   assign o_rsp_hit    = w_rsp_hit;
   assign o_rsp_taken  = w_rsp_hit & w_ent.ctr[1];
   assign o_rsp_target = r_rsp_pend ?
                         {w_ent.tgt, 2'b00} : 32'd0;

   // Reset gates the write strobe so nothing is written
   // while reset is held in the INIT state.
   assign o_ram_we    = w_we & ~i_rst;
   assign o_ram_addr  = w_addr;
   assign o_ram_din   = w_din;
   assign o_lk_ready  = w_lk_ready;
   assign o_upd_ready = ~w_full;

   // ---------------- perf counters ----------------
`ifdef BPU_PERF_CNT_EN
   logic [31:0] r_perf_lk;
   logic [31:0] r_perf_hit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_perf_lk  <= '0;
         r_perf_hit <= '0;
      end else begin
         if (w_lk_acc)
            r_perf_lk <= r_perf_lk + 32'd1;
         if (w_rsp_hit)
            r_perf_hit <= r_perf_hit + 32'd1;
      end
   end

   assign o_perf_lk  = r_perf_lk;
   assign o_perf_hit = r_perf_hit;
`else
   assign o_perf_lk  = 32'd0;
   assign o_perf_hit = 32'd0;
`endif

   assign w_unused = ^{i_lk_pc[31:16], i_lk_pc[1:0],
                       i_upd_pc[31:16], i_upd_pc[1:0],
                       i_upd_target[1:0]};

endmodule

// File: tb/tb_bpu_btb_ctrl.sv
// tb_bpu_btb_ctrl: self-checking bench for bpu_btb_ctrl with a
// behavioural RAM and a transaction-level BTB reference model.

module tb_bpu_btb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        lk_valid, lk_ready;
   logic [31:0] lk_pc;
   logic        rsp_valid, rsp_hit, rsp_taken;
   logic [31:0] rsp_target;
   logic        upd_valid, upd_ready, upd_taken;
   logic [31:0] upd_pc, upd_target;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [38:0] ram_din, ram_dout;
   logic [31:0] perf_lk, perf_hit;

   always #5 clk = ~clk;

   bpu_btb_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_lk_valid(lk_valid), .o_lk_ready(lk_ready), .i_lk_pc(lk_pc),
      .o_rsp_valid(rsp_valid), .o_rsp_hit(rsp_hit),
      .o_rsp_taken(rsp_taken), .o_rsp_target(rsp_target),
      .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
      .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
      .i_upd_target(upd_target),
      .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
      .i_ram_dout(ram_dout),
      .o_perf_lk(perf_lk), .o_perf_hit(perf_hit)
   );

   // single_port_ram_bpu behaviour: 1-cycle read, write-first
   logic [38:0] mem [256];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         ram_dout      <= ram_din;
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   // reference model: one record per BTB index
   typedef struct {
      bit          vld;
      int          ctr;
      bit [5:0]    tag;
      bit [31:0]   tgt;
   } mentry_t;

   mentry_t btb [256];
   int exp_lk, exp_hit;
   int n_vec, n_err;

   function automatic void model_clear();
      foreach (btb[i]) btb[i] = '{0, 0, 6'd0, 32'd0};
      exp_lk  = 0;
      exp_hit = 0;
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int i = int'(pc[9:2]);
      return btb[i].vld && (btb[i].tag == pc[15:10]);
   endfunction

   function automatic void model_update(input logic [31:0] pc,
                                        input bit tk,
                                        input logic [31:0] tgt);
      int i = int'(pc[9:2]);
      if (model_hit(pc)) begin
         if (tk) btb[i].ctr = (btb[i].ctr == 3) ? 3 : btb[i].ctr + 1;
         else    btb[i].ctr = (btb[i].ctr == 0) ? 0 : btb[i].ctr - 1;
         if (tk) btb[i].tgt = {tgt[31:2], 2'b00};
      end else if (tk) begin
         btb[i] = '{1, 2, pc[15:10], {tgt[31:2], 2'b00}};
      end
   endfunction

   function automatic void predict(input logic [31:0] pc,
                                   output bit h, output bit t,
                                   output logic [31:0] g);
      int i = int'(pc[9:2]);
      h = model_hit(pc);
      t = h && (btb[i].ctr >= 2);
      g = btb[i].tgt;
      exp_lk++;
      if (h) exp_hit++;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [7:0] ix;
      logic [5:0] tg;
      case ($urandom_range(0, 3))
         0:       ix = 8'h8D;
         1:       ix = 8'h10;
         2:       ix = 8'h11;
         default: ix = 8'hFF;
      endcase
      tg = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h3F;
      return {16'($urandom), tg, ix, 2'($urandom)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      bit eh, et;
      logic [31:0] eg;
      int n = 0;
      cyc();
      lk_valid = 1'b1;
      lk_pc    = pc;
      #1;
      while (!lk_ready && n < 16) begin
         cyc(); #1; n++;
      end
      n_vec++;
      if (lk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL lk_accept timeout pc=%h", pc);
         lk_valid = 1'b0;
      end else begin
         predict(pc, eh, et, eg);
         cyc();
         lk_valid = 1'b0;
         #1;
         n_vec++;
         if (rsp_valid !== 1'b1 || rsp_hit !== eh ||
             rsp_taken !== et || rsp_target !== eg) begin
            n_err++;
            $display("FAIL lookup pc=%h got v%b h%b t%b %h want v1 h%b t%b %h",
                     pc, rsp_valid, rsp_hit, rsp_taken, rsp_target,
                     eh, et, eg);
         end
      end
   endtask

   task automatic do_update(input logic [31:0] pc, input bit tk,
                            input logic [31:0] tgt);
      int n = 0;
      cyc();
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_taken  = tk;
      upd_target = tgt;
      #1;
      while (!upd_ready && n < 16) begin
         cyc(); #1; n++;
      end
      n_vec++;
      if (upd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL upd_accept timeout pc=%h", pc);
      end
      cyc();
      upd_valid = 1'b0;
      repeat (3) cyc();
      model_update(pc, tk, tgt);
   endtask

   // tests 1 and 2: reset state, sweep, first lookup
   task automatic test_reset();
      bit eh, et;
      logic [31:0] eg;
      rst = 1'b1;
      lk_valid = 1'b1; lk_pc = 32'h0000_1234;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if ({lk_ready, rsp_valid, rsp_hit, rsp_taken, ram_we} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctl got %b want 00000",
                  {lk_ready, rsp_valid, rsp_hit, rsp_taken, ram_we});
      end
      n_vec++;
      if (ram_addr !== 8'd0 || rsp_target !== 32'd0) begin
         n_err++;
         $display("FAIL reset_addr got %h/%h want 0/0", ram_addr, rsp_target);
      end
      n_vec++;
      if (upd_ready !== 1'b1 || perf_lk !== 32'd0 || perf_hit !== 32'd0) begin
         n_err++;
         $display("FAIL reset_fifo_perf got %b %h %h want 1 0 0",
                  upd_ready, perf_lk, perf_hit);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      for (int c = 0; c < 256; c++) begin
         #1;
         n_vec++;
         if (lk_ready !== 1'b0 || ram_we !== 1'b1 ||
             ram_addr !== c[7:0] || ram_din !== 39'd0) begin
            n_err++;
            $display("FAIL sweep c=%0d got rdy%b we%b a%h d%h want 0 1 %h 0",
                     c, lk_ready, ram_we, ram_addr, ram_din, c[7:0]);
         end
         cyc();
      end
      #1;
      n_vec++;
      if (lk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_257 got %b want 1", lk_ready);
      end
      predict(lk_pc, eh, et, eg);
      cyc();
      lk_valid = 1'b0;
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_hit !== eh || rsp_taken !== et ||
          rsp_target !== eg) begin
         n_err++;
         $display("FAIL first_lookup got v%b h%b t%b %h want 1 %b %b %h",
                  rsp_valid, rsp_hit, rsp_taken, rsp_target, eh, et, eg);
      end
   endtask

   // test 3
   task automatic test_alloc();
      do_update(32'h0000_1234, 1'b1, 32'h8000_0040);
      do_lookup(32'h0000_1234);
   endtask

   // test 4
   task automatic test_ctr_sat();
      do_update(32'h0000_1234, 1'b0, 32'h1111_1110);
      do_lookup(32'h0000_1234);
      do_update(32'h0000_1234, 1'b0, 32'h2222_2220);
      do_lookup(32'h0000_1234);
      do_update(32'h0000_1234, 1'b0, 32'h3333_3330);
      do_lookup(32'h0000_1234);
      do_update(32'h0000_1234, 1'b1, 32'h8000_0080);
      do_lookup(32'h0000_1234);
   endtask

   // test 5: updates fill the FIFO under continuous lookups
   task automatic test_back_to_back();
      bit rdy_tab [7]  = '{1, 1, 0, 0, 1, 1, 0};
      bit updr_tab [7] = '{1, 1, 0, 0, 1, 1, 1};
      logic [31:0] p [4];
      logic [31:0] u_pc [2], u_tg [2];
      bit u_tk [2];
      bit due, eh, et, ewe, h_nx, t_nx;
      logic [31:0] eg, g_nx;
      logic [38:0] edin;
      int i1;
      for (int k = 0; k < 4; k++) p[k] = rand_pc();
      for (int k = 0; k < 2; k++) begin
         u_pc[k] = rand_pc();
         u_tk[k] = ($urandom_range(0, 1) != 0);
         u_tg[k] = $urandom;
      end
      due = 1'b0; eh = 0; et = 0; eg = '0;
      for (int w = 0; w < 7; w++) begin
         cyc();
         case (w)
            0: begin
               lk_valid = 1'b1; lk_pc = p[0];
               upd_valid = 1'b1; upd_pc = u_pc[0];
               upd_taken = u_tk[0]; upd_target = u_tg[0];
            end
            1: begin
               lk_pc = p[1];
               upd_pc = u_pc[1];
               upd_taken = u_tk[1]; upd_target = u_tg[1];
            end
            2: begin upd_valid = 1'b0; lk_pc = p[2]; end
            5: lk_pc = p[3];
            6: lk_valid = 1'b0;
            default: ;
         endcase
         #1;
         n_vec++;
         if (lk_ready !== rdy_tab[w] || upd_ready !== updr_tab[w]) begin
            n_err++;
            $display("FAIL b2b_ready w=%0d got %b%b want %b%b",
                     w, lk_ready, upd_ready, rdy_tab[w], updr_tab[w]);
         end
         n_vec++;
         if (due) begin
            if (rsp_valid !== 1'b1 || rsp_hit !== eh ||
                rsp_taken !== et || rsp_target !== eg) begin
               n_err++;
               $display("FAIL b2b_rsp w=%0d got v%b h%b t%b %h want 1 %b %b %h",
                        w, rsp_valid, rsp_hit, rsp_taken, rsp_target,
                        eh, et, eg);
            end
         end else if (rsp_valid !== 1'b0 || rsp_target !== 32'd0) begin
            n_err++;
            $display("FAIL b2b_norsp w=%0d got v%b %h want 0 0",
                     w, rsp_valid, rsp_target);
         end
         if (w == 2) begin
            n_vec++;
            if (ram_we !== 1'b0 || ram_addr !== u_pc[0][9:2]) begin
               n_err++;
               $display("FAIL b2b_rd got we%b a%h want 0 %h",
                        ram_we, ram_addr, u_pc[0][9:2]);
            end
         end
         if (w == 3) begin
            ewe = model_hit(u_pc[0]) || u_tk[0];
            model_update(u_pc[0], u_tk[0], u_tg[0]);
            i1 = int'(u_pc[0][9:2]);
            edin = {1'b1, 2'(btb[i1].ctr), btb[i1].tag, btb[i1].tgt[31:2]};
            n_vec++;
            if (ram_we !== ewe || ram_addr !== u_pc[0][9:2] ||
                (ewe && ram_din !== edin)) begin
               n_err++;
               $display("FAIL b2b_wr got we%b a%h d%h want %b %h %h",
                        ram_we, ram_addr, ram_din, ewe, u_pc[0][9:2], edin);
            end
         end
         due = lk_valid && rdy_tab[w];
         if (due) begin
            predict(lk_pc, h_nx, t_nx, g_nx);
            eh = h_nx; et = t_nx; eg = g_nx;
         end
      end
      repeat (3) cyc();
      model_update(u_pc[1], u_tk[1], u_tg[1]);
      do_lookup(u_pc[1]);
      do_lookup(u_pc[0]);
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) != 0)
            do_update(rand_pc(), ($urandom_range(0, 3) != 0), $urandom);
         else
            do_lookup(rand_pc());
      end
   endtask

   task automatic test_perf();
      n_vec++;
`ifdef BPU_PERF_CNT_EN
      if (perf_lk !== 32'(exp_lk) || perf_hit !== 32'(exp_hit)) begin
         n_err++;
         $display("FAIL perf got %0d/%0d want %0d/%0d",
                  perf_lk, perf_hit, exp_lk, exp_hit);
      end
`else
      if (perf_lk !== 32'd0 || perf_hit !== 32'd0) begin
         n_err++;
         $display("FAIL perf_tied got %h/%h want 0/0", perf_lk, perf_hit);
      end
`endif
   endtask

   // test 6: reset while an update is in its write cycle
   task automatic test_reset_mid();
      logic [31:0] a, b;
      a = 32'h0000_1234;
      b = rand_pc();
      cyc();
      lk_valid = 1'b0;
      upd_valid = 1'b1; upd_pc = a; upd_taken = 1'b1;
      upd_target = 32'h8000_0100;
      cyc();
      upd_pc = b; upd_taken = 1'b1; upd_target = 32'h4000_0200;
      #1;
      n_vec++;
      if (ram_we !== 1'b0 || ram_addr !== a[9:2] || lk_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_rd got we%b a%h rdy%b want 0 %h 0",
                  ram_we, ram_addr, lk_ready, a[9:2]);
      end
      cyc();
      upd_valid = 1'b0;
      #1;
      n_vec++;
      if (upd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_full got %b want 0", upd_ready);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || lk_ready !== 1'b0 ||
          upd_ready !== 1'b1 || perf_lk !== 32'd0 || perf_hit !== 32'd0) begin
         n_err++;
         $display("FAIL mid_rst got v%b we%b rdy%b ur%b %h %h want 0 0 0 1 0 0",
                  rsp_valid, ram_we, lk_ready, upd_ready, perf_lk, perf_hit);
      end
      model_clear();
      cyc();
      cyc();
      rst = 1'b0;
      for (int c = 0; c < 256; c++) begin
         #1;
         n_vec++;
         if (ram_we !== 1'b1 || ram_addr !== c[7:0] || ram_din !== 39'd0) begin
            n_err++;
            $display("FAIL resweep c=%0d got we%b a%h want 1 %h",
                     c, ram_we, ram_addr, c[7:0]);
         end
         cyc();
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++;
         if (ram_we !== 1'b0 || lk_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flushed c=%0d got we%b rdy%b want 0 1",
                     c, ram_we, lk_ready);
         end
         cyc();
      end
      do_lookup(a);
      do_lookup(b);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      foreach (mem[i]) mem[i] = 39'({$urandom, $urandom});
      ram_dout = '0;
      test_reset();
      test_alloc();
      test_ctr_sat();
      for (int r = 0; r < 4; r++) test_back_to_back();
      test_random();
      test_perf();
      test_reset_mid();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
